// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters into a UART transmit core.
// After each write it holds off for HOLD_CYC cycles before trusting TXrd again.
module uart_tx_arbiter #(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    input  logic        TXrd,
    output logic [7:0]  TX,
    output logic        wen,
    output logic [1:0]  grant_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tx_d;
    logic [3:0]  ack_d;
    logic        wen_d;
    logic [1:0]  gid_d;
    logic        busy_d;

    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;

    // Scan from ptr upward, wrapping; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tx_d    = TX;
        ack_d   = ack;
        wen_d   = wen;
        gid_d   = grant_id;
        case (state_q)
            IDLE: begin
                if (TXrd && (req != 4'b0000))
                    state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    state_d = WRITE;
                    tx_d    = req_data[{win, 3'b000} +: 8];
                    gid_d   = win;
                    ack_d   = 4'b0001 << win;
                    wen_d   = 1'b0;
                    ptr_d   = win + 2'd1;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = HOLD;
                wen_d   = 1'b1;
                ack_d   = 4'b0000;
            end
            HOLD: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                // The last counting cycle may already leave if TXrd is up.
                if ((cnt_q <= 4'd1) && TXrd)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= 4'd0;
            TX       <= 8'h00;
            ack      <= 4'b0000;
            wen      <= 1'b1;
            grant_id <= 2'd0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            TX       <= tx_d;
            ack      <= ack_d;
            wen      <= wen_d;
            grant_id <= gid_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin,
// flow control, withdrawn request and reset during a write.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        TXrd;
    logic [7:0]  TX;
    logic        wen;
    logic [1:0]  grant_id;
    logic        busy;

    int tests_run;
    int tests_failed;

    uart_tx_arbiter #(.HOLD_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .TXrd     (TXrd),
        .TX       (TX),
        .wen      (wen),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b0000; req_data = 32'h0; TXrd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({TX, wen, ack, grant_id, busy} !== {8'h00, 1'b1, 4'b0000, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: TX=%h wen=%b ack=%b gid=%0d busy=%b, want 00 1 0000 0 0",
                     TX, wen, ack, grant_id, busy);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        TXrd = 1'b1; req_data = 32'h00A5_0000; req = 4'b0100;
        tick();
        tests_run++;
        if (busy !== 1'b1 || wen !== 1'b1 || ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_arb: busy=%b wen=%b ack=%b, want 1 1 0000", busy, wen, ack);
        end
        tick();
        tests_run++;
        if (TX !== 8'hA5 || ack !== 4'b0100 || wen !== 1'b0 || grant_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_write: TX=%h ack=%b wen=%b gid=%0d, want a5 0100 0 2",
                     TX, ack, wen, grant_id);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (wen !== 1'b1 || ack !== 4'b0000 || TX !== 8'hA5 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hold: wen=%b ack=%b TX=%h busy=%b, want 1 0000 a5 1",
                     wen, ack, TX, busy);
        end
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hold_len: busy=%b after 3 hold cycles, want 1", busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: busy=%b after 4 hold cycles, want 0", busy);
        end
        wait_idle(ok);
    endtask

    task automatic test_round_robin();
        logic [7:0] bytes [4];
        logic [3:0] acks  [5];
        logic [7:0] txs   [5];
        int         when  [5];
        int         n, wen_lows, bad_wen;
        bit         ok;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        n = 0; wen_lows = 0; bad_wen = 0;
        do_reset();
        req_data = 32'h4433_2211; TXrd = 1'b1; req = 4'b1111;
        for (int cyc = 1; cyc <= 60 && n < 5; cyc++) begin
            tick();
            if (wen === 1'b0) wen_lows++;
            if ((wen === 1'b0) != (ack !== 4'b0000)) bad_wen++;
            if (ack !== 4'b0000) begin
                acks[n] = ack; txs[n] = TX; when[n] = cyc;
                n++;
                if (n == 5) req = 4'b0000;
            end
        end
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL rr_count: saw %0d acks, want 5", n);
        end
        for (int k = 0; k < n; k++) begin
            tests_run++;
            if (acks[k] !== (4'b0001 << (k % 4)) || txs[k] !== bytes[k % 4]) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: ack=%b TX=%h, want %b %h",
                         k, acks[k], txs[k], 4'b0001 << (k % 4), bytes[k % 4]);
            end
            if (k > 0) begin
                tests_run++;
                if (when[k] - when[k-1] != 7) begin
                    tests_failed++;
                    $display("FAIL rr_spacing%0d: %0d cycles, want 7", k, when[k] - when[k-1]);
                end
            end
        end
        tests_run++;
        if (wen_lows != 5 || bad_wen != 0) begin
            tests_failed++;
            $display("FAIL rr_wen: wen low %0d cycles, %0d misaligned with ack, want 5 and 0",
                     wen_lows, bad_wen);
        end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rr_idle_timeout: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_flow_control();
        int bad;
        bit ok;
        bad = 0;
        TXrd = 1'b1; req = 4'b0100;
        tick();
        tick();
        tests_run++;
        if (ack !== 4'b0100 || wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL flow_write: ack=%b wen=%b, want 0100 0", ack, wen);
        end
        TXrd = 1'b0; req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b1 || wen !== 1'b1 || ack !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL flow_stall: %0d bad cycles (busy=%b wen=%b ack=%b), want 0",
                     bad, busy, wen, ack);
        end
        TXrd = 1'b1; req = 4'b0001;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flow_release: busy=%b, want 0", busy);
        end
        tick();
        tick();
        tests_run++;
        if (ack !== 4'b0001 || TX !== 8'h11 || grant_id !== 2'd0 || wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL flow_next: ack=%b TX=%h gid=%0d wen=%b, want 0001 11 0 0",
                     ack, TX, grant_id, wen);
        end
        req = 4'b0000;
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL flow_idle_timeout: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_withdrawn();
        bit ok;
        TXrd = 1'b1; req = 4'b0010;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_arb: busy=%b, want 1", busy);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (busy !== 1'b0 || ack !== 4'b0000 || wen !== 1'b1 || TX !== 8'h11) begin
            tests_failed++;
            $display("FAIL wd_lost: busy=%b ack=%b wen=%b TX=%h, want 0 0000 1 11",
                     busy, ack, wen, TX);
        end
        req = 4'b1111;
        tick();
        tick();
        tests_run++;
        if (ack !== 4'b0010 || grant_id !== 2'd1 || TX !== 8'h22) begin
            tests_failed++;
            $display("FAIL wd_ptr: ack=%b gid=%0d TX=%h, want 0010 1 22", ack, grant_id, TX);
        end
        req = 4'b0000;
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wd_idle_timeout: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        TXrd = 1'b1; req = 4'b0001;
        tick();
        tick();
        tests_run++;
        if (wen !== 1'b0 || ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rmw_write: wen=%b ack=%b, want 0 0001", wen, ack);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (wen !== 1'b1 || ack !== 4'b0000 || TX !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rmw_async: wen=%b ack=%b TX=%h busy=%b gid=%0d, want 1 0000 00 0 0",
                     wen, ack, TX, busy, grant_id);
        end
        req = 4'b1000;
        #2;
        rst = 1'b1;
        tick();
        tests_run++;
        if (wen !== 1'b1 || ack !== 4'b0000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmw_arb: wen=%b ack=%b busy=%b, want 1 0000 1", wen, ack, busy);
        end
        tick();
        tests_run++;
        if (ack !== 4'b1000 || grant_id !== 2'd3 || TX !== 8'h44 || wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_regrant: ack=%b gid=%0d TX=%h wen=%b, want 1000 3 44 0",
                     ack, grant_id, TX, wen);
        end
        req = 4'b0000;
        wait_idle(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rmw_idle_timeout: busy=%b, want 0", busy);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_flow_control();
        test_withdrawn();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The parameter list SHALL be: HOLD_CYC, 4, number of cycles after a write strobe before TXrd is trusted again (range 1..15).
REQ-002 The port list SHALL be as follows; clock and reset are listed first, and the block uses one clock with asynchronous active-low reset.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-requester byte-send request, bit i = requester i.
REQ-006 req_data  input  32  requester i byte on bits [8i+7:8i], stable while req[i] high.
REQ-007 ack  output  4  one-cycle pulse, bit i = byte of requester i accepted.
REQ-008 TXrd  input  1  UART core transmit-ready, active high.
REQ-009 TX  output  8  byte presented to the UART core data input.
REQ-010 wen  output  1  UART core write enable, active low.
REQ-011 grant_id  output  2  index of last granted requester.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ARB, WRITE and HOLD; all outputs SHALL be registered.
REQ-014 In IDLE, when TXrd=1 and req!=0 are sampled, the next state SHALL be ARB; otherwise the FSM SHALL stay in IDLE.
REQ-015 ARB SHALL last 1 cycle: winner = first set bit of req scanning ptr, ptr+1, ... mod 4, with req sampled at the ARB edge.
REQ-016 If req=0 at the ARB edge, the FSM SHALL return to IDLE with no ack, no wen and TX unchanged.
REQ-017 On the ARB->WRITE edge the block SHALL load TX<=req_data[winner], grant_id<=winner, ack[winner]<=1, wen<=0 and ptr<=(winner+1) mod 4.
REQ-018 WRITE SHALL last exactly 1 cycle with wen=0 and ack one-hot; on exit, wen<=1, ack<=0 and next state = HOLD.
REQ-019 HOLD SHALL count HOLD_CYC cycles (4-bit counter, loaded on WRITE entry) and ignore TXrd while counting.
REQ-020 After the count expires, HOLD SHALL wait until TXrd=1, then go to IDLE.
REQ-021 TX SHALL hold its last value until the next ARB->WRITE edge.
REQ-022 wen SHALL be low for exactly one cycle per accepted byte, and never low outside WRITE.
REQ-023 Latency: req/TXrd sampled in IDLE at edge E0 -> ARB at E1 -> wen=0 and ack=1 in the cycle after E2.
REQ-024 Minimum byte period with TXrd always 1 SHALL be 3+HOLD_CYC cycles.
REQ-025 A requester holding req high after ack SHALL be treated as a new byte and rearbitrated.
REQ-026 Fairness: with all req bits constantly high, grant order SHALL be 0,1,2,3,0,... with no requester skipped.
REQ-027 A req dropped before the ARB edge SHALL lose that round with no ack; ptr SHALL be unchanged when no grant occurs.
REQ-028 busy SHALL equal (state!=IDLE), registered with the state.

Reset
REQ-029 While rst=0, the block SHALL hold state=IDLE, ptr=0, TX=8'h00, wen=1, ack=4'b0000, grant_id=0, busy=0 and the hold counter at 0.
REQ-030 Reset asserted in any state SHALL take effect immediately (asynchronously): wen forced to 1 and ack to 0, with no partial or repeated write after release.
REQ-031 After rst rises, the first arbitration SHALL start from requester 0.

Verification
REQ-032 Single request: req=4'b0100, req_data[23:16]=8'hA5, TXrd=1 -> TX=8'hA5, ack=4'b0100, wen=0 for one cycle, grant_id=2, 2 cycles after the request edge.
REQ-033 Round-robin: req=4'b1111 held, TXrd=1, HOLD_CYC=4 -> acks 0,1,2,3,0 exactly 7 cycles apart, one wen pulse each.
REQ-034 Flow control: TXrd=0 from WRITE for 20 cycles -> FSM stays in HOLD, wen=1, no ack; after TXrd=1, next grant follows.
REQ-035 Withdrawn request: req[1] pulsed for one cycle, deasserted before the ARB edge -> return to IDLE, ack=0, wen=1, ptr unchanged.
REQ-036 Reset mid-write: rst=0 during WRITE -> wen=1 and ack=0 immediately, TX=8'h00; after release with req=4'b1000, grant goes to 3 via ptr=0 scan.
